// File: rtl/jtbubl_sdram_rsp_pkg.sv
// Shared definitions for the jtbubl SDRAM responder: SDRAM command
// encodings, controller state encoding and the mode-register word builder.
package jtbubl_sdram_rsp_pkg;

  // Commands as {nCS, nRAS, nCAS, nWE}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_REFRESH
  } state_e;

  // Mode register: single-location write burst (A9=1), CAS latency,
  // sequential burst type, burst length 1.
  function automatic logic [12:0] mode_word(input logic [2:0] cas);
    return {3'b000, 1'b1, 2'b00, cas, 1'b0, 3'b000};
  endfunction

  // True while the power-up sequence is still running.
  function automatic logic in_init(input state_e s);
    return (s == ST_INIT_WAIT) || (s == ST_INIT_PRE) || (s == ST_INIT_REF1) ||
           (s == ST_INIT_REF2) || (s == ST_INIT_MRS);
  endfunction

endpackage

// File: rtl/jtbubl_sdram_rsp_refcnt.sv
// Refresh timer: counts cycles since the last refresh credit, saturating,
// and flags when a refresh is due or overdue.
module jtbubl_sdram_rsp_refcnt #(
  parameter int REF_PERIOD = 374
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic refresh_done,
  output logic due,
  output logic overdue
);
  localparam int MAXC = 4 * REF_PERIOD;
  localparam int W    = $clog2(MAXC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: pay back one period per refresh (floored), else tick up to the cap
  always_comb begin
    cnt_d = cnt_q;
    if (refresh_done) begin
      cnt_d = (cnt_q >= W'(REF_PERIOD)) ? cnt_q - W'(REF_PERIOD) : '0;
    end else if (en && (cnt_q != W'(MAXC))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign due     = cnt_q >= W'(REF_PERIOD);
  assign overdue = cnt_q >= W'(2 * REF_PERIOD);

endmodule

// File: rtl/jtbubl_sdram_rsp.sv
// SDRAM responder for the ROM-slot request interface: runs the power-up
// sequence, then services 32-bit reads (two single-word READs with
// auto-precharge on the second), download byte writes and auto refresh.
// All pin-facing outputs are registered.
module jtbubl_sdram_rsp
  import jtbubl_sdram_rsp_pkg::*;
#(
  parameter int INIT_WAIT  = 4800,
  parameter int TRCD       = 2,
  parameter int CL         = 2,
  parameter int TRP        = 2,
  parameter int TRFC       = 7,
  parameter int REF_PERIOD = 374
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  input  logic        refresh_en,
  output logic        sdram_ack,
  output logic        data_rdy,
  output logic [31:0] data_read,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_ba,
  output logic [3:0]  sd_cmd,
  output logic [1:0]  sd_dqm,
  output logic        sd_cke,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe
);
  localparam int CW = 13;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] a_q, a_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        ack_q, ack_d;
  logic        rdy_q, rdy_d;
  logic [31:0] data_read_q, data_read_d;
  logic [8:0]  col_q, col_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [1:0]  wr_mask_q, wr_mask_d;
  logic [15:0] low_q, low_d;
  logic        ref_done, ref_due, ref_overdue;

  jtbubl_sdram_rsp_refcnt #(.REF_PERIOD(REF_PERIOD)) u_refcnt (
    .clk          (clk),
    .rstn         (rstn),
    .en           (!in_init(state_q)),
    .refresh_done (ref_done),
    .due          (ref_due),
    .overdue      (ref_overdue)
  );

  // Next-state, command and datapath decisions; cnt counts cycles in a state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    cmd_d       = CMD_NOP;
    a_d         = a_q;
    dqm_d       = 2'b11;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    ack_d       = 1'b0;
    rdy_d       = 1'b0;
    data_read_d = data_read_q;
    col_d       = col_q;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    low_d       = low_q;
    ref_done    = 1'b0;
    case (state_q)
      ST_INIT_WAIT: if (cnt_q == CW'(INIT_WAIT - 1)) begin
        cmd_d   = CMD_PRE;
        a_d     = 13'h0400;  // A10: all banks
        state_d = ST_INIT_PRE;
        cnt_d   = '0;
      end
      ST_INIT_PRE: if (cnt_q == CW'(TRP - 1)) begin
        cmd_d   = CMD_REF;
        state_d = ST_INIT_REF1;
        cnt_d   = '0;
      end
      ST_INIT_REF1: if (cnt_q == CW'(TRFC - 1)) begin
        cmd_d   = CMD_REF;
        state_d = ST_INIT_REF2;
        cnt_d   = '0;
      end
      ST_INIT_REF2: if (cnt_q == CW'(TRFC - 1)) begin
        cmd_d   = CMD_MRS;
        a_d     = mode_word(3'(CL));
        state_d = ST_INIT_MRS;
      end
      ST_INIT_MRS: state_d = ST_IDLE;
      ST_IDLE: begin
        cnt_d = '0;
        if (ref_overdue || (!(downloading && prog_we) && ref_due && refresh_en)) begin
          cmd_d    = CMD_REF;
          ref_done = 1'b1;
          state_d  = ST_REFRESH;
        end else if (downloading && prog_we) begin
          cmd_d     = CMD_ACT;
          a_d       = prog_addr[21:9];
          col_d     = prog_addr[8:0];
          wr_data_d = prog_data;
          wr_mask_d = prog_mask;
          ack_d     = 1'b1;
          state_d   = ST_WRITE;
        end else if (!downloading && sdram_req) begin
          cmd_d   = CMD_ACT;
          a_d     = sdram_addr[21:9];
          col_d   = sdram_addr[8:0];
          ack_d   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Second word wraps inside the row at column 511
        if (cnt_q == CW'(TRCD - 1)) begin
          cmd_d = CMD_RD;
          a_d   = {4'b0000, col_q};
          dqm_d = 2'b00;
        end else if (cnt_q == CW'(TRCD)) begin
          cmd_d = CMD_RD;
          a_d   = {2'b00, 1'b1, 1'b0, col_q + 9'd1};
          dqm_d = 2'b00;
        end else if (cnt_q == CW'(TRCD + CL + 1)) begin
          low_d = dq_in;
        end else if (cnt_q == CW'(TRCD + CL + 2)) begin
          data_read_d = {dq_in, low_q};
          rdy_d       = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_q == CW'(TRCD - 1)) begin
          cmd_d    = CMD_WR;
          a_d      = {2'b00, 1'b1, 1'b0, col_q};
          dq_oe_d  = 1'b1;
          dq_out_d = {wr_data_q, wr_data_q};
          dqm_d    = wr_mask_q;
        end else if (cnt_q == CW'(TRCD + TRP)) begin
          state_d = ST_IDLE;
        end
      end
      ST_REFRESH: if (cnt_q == CW'(TRFC - 1)) state_d = ST_IDLE;
      default: begin
        state_d = ST_INIT_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered pin/handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_INIT_WAIT;
      cnt_q       <= '0;
      cmd_q       <= CMD_NOP;
      a_q         <= '0;
      dqm_q       <= 2'b11;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      ack_q       <= 1'b0;
      rdy_q       <= 1'b0;
      data_read_q <= '0;
      col_q       <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= 2'b11;
      low_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      dqm_q       <= dqm_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      ack_q       <= ack_d;
      rdy_q       <= rdy_d;
      data_read_q <= data_read_d;
      col_q       <= col_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      low_q       <= low_d;
    end
  end

  assign sd_cmd    = cmd_q;
  assign sd_a      = a_q;
  assign sd_ba     = 2'b00;
  assign sd_cke    = 1'b1;
  assign sd_dqm    = dqm_q;
  assign dq_oe     = dq_oe_q;
  assign dq_out    = dq_out_q;
  assign sdram_ack = ack_q;
  assign data_rdy  = rdy_q;
  assign data_read = data_read_q;

endmodule

// File: tb/tb_jtbubl_sdram_rsp.sv
// Bench for jtbubl_sdram_rsp: a small SDRAM model, a read-data scoreboard
// and a directed sequence covering init, read, write, priority, refresh
// and reset mid-transaction.
module tb_jtbubl_sdram_rsp;
  import jtbubl_sdram_rsp_pkg::*;

  localparam int MCL = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sdram_req, refresh_en, downloading, prog_we;
  logic [21:0] sdram_addr, prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        sdram_ack, data_rdy, sd_cke, dq_oe;
  logic [31:0] data_read;
  logic [12:0] sd_a;
  logic [1:0]  sd_ba, sd_dqm;
  logic [3:0]  sd_cmd;
  logic [15:0] dq_in = 16'h0000;
  logic [15:0] dq_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ref_cyc = 0;

  logic [15:0] mem [int];
  logic [31:0] sb [$];
  logic [15:0] rd_val [0:7];
  logic        rd_vld [0:7];
  logic [12:0] act_row = '0;

  jtbubl_sdram_rsp dut (
    .clk(clk), .rstn(rstn), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .refresh_en(refresh_en), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read), .downloading(downloading), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .sd_a(sd_a), .sd_ba(sd_ba), .sd_cmd(sd_cmd), .sd_dqm(sd_dqm),
    .sd_cke(sd_cke), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter and read-data return path of the SDRAM model
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rd_vld[cyc % 8]) begin
      dq_in = rd_val[cyc % 8];
      rd_vld[cyc % 8] = 1'b0;
    end else begin
      dq_in = 16'h0000;
    end
  end

  // SDRAM model command decode
  always @(negedge clk) begin
    int ad;
    if (rstn) begin
      if (sd_cmd == CMD_ACT) act_row = sd_a;
      if (sd_cmd == CMD_REF) last_ref_cyc = cyc;
      if (sd_cmd == CMD_RD) begin
        ad = int'({act_row, sd_a[8:0]});
        rd_val[(cyc + MCL + 1) % 8] = mem.exists(ad) ? mem[ad] : 16'h0000;
        rd_vld[(cyc + MCL + 1) % 8] = 1'b1;
      end
      if (sd_cmd == CMD_WR) begin
        ad = int'({act_row, sd_a[8:0]});
        if (!mem.exists(ad)) mem[ad] = 16'h0000;
        if (!sd_dqm[0]) mem[ad][7:0]  = dq_out[7:0];
        if (!sd_dqm[1]) mem[ad][15:8] = dq_out[15:8];
        $display("write addr=0x%0h dq=0x%0h dqm=%b -> mem=0x%0h", ad, dq_out, sd_dqm, mem[ad]);
      end
    end
  end

  // Scoreboard monitor: every data_rdy pops one expected read
  always @(negedge clk) begin
    logic [31:0] exp;
    if (data_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_data_rdy: got data_read=0x%0h, expected no pulse", data_read);
      end else begin
        exp = sb.pop_front();
        check("read_data", data_read, exp);
        $display("read data_read=0x%08h expected=0x%08h", data_read, exp);
      end
    end
  end

  task automatic wait_cmd(input logic [3:0] want, input int limit, input string name,
                          output int t, output logic [12:0] a);
    t = -1;
    a = '0;
    for (int i = 0; i < limit && t < 0; i++) begin
      @(negedge clk);
      if (sd_cmd == want) begin
        t = cyc;
        a = sd_a;
      end
    end
    if (t < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: command %b not seen within %0d cycles", name, want, limit);
    end
  endtask

  task automatic wait_flag(input bit rdy_sel, input int limit, input string name, output int t);
    t = -1;
    for (int i = 0; i < limit && t < 0; i++) begin
      @(negedge clk);
      if ((rdy_sel ? data_rdy : sdram_ack) == 1'b1) t = cyc;
    end
    if (t < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no pulse within %0d cycles, expected one", name, limit);
    end
  endtask

  task automatic check_init(input int c0);
    int t;
    logic [12:0] a;
    wait_cmd(CMD_PRE, 5000, "init_pre_wait", t, a);
    check("init_pre_cycle", t - c0, 4800);
    check("init_pre_a10", {31'd0, a[10]}, 1);
    wait_cmd(CMD_REF, 10, "init_ref1_wait", t, a);
    check("init_ref1_cycle", t - c0, 4802);
    wait_cmd(CMD_REF, 20, "init_ref2_wait", t, a);
    check("init_ref2_cycle", t - c0, 4809);
    wait_cmd(CMD_MRS, 20, "init_mrs_wait", t, a);
    check("init_mrs_cycle", t - c0, 4816);
    check("init_mrs_cl", {29'd0, a[6:4]}, 2);
    check("init_mrs_word", {22'd0, a[9:0]}, 32'h220);
  endtask

  int t, t2, c0, c1, idle0, acks, nrd;
  logic [12:0] a;

  initial begin
    for (int i = 0; i < 8; i++) begin rd_vld[i] = 1'b0; rd_val[i] = 16'h0; end
    mem[32'h400] = 16'h1234;
    mem[32'h401] = 16'hABCD;
    mem[32'h011] = 16'hC3C3;
    mem[32'h021] = 16'h9876;
    rstn = 1'b0; sdram_req = 1'b0; sdram_addr = '0; refresh_en = 1'b0;
    downloading = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_mask = 2'b11;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cmd", {28'd0, sd_cmd}, 32'h7);
    check("rst_cke", {31'd0, sd_cke}, 1);
    check("rst_dq_oe", {31'd0, dq_oe}, 0);
    check("rst_dqm", {30'd0, sd_dqm}, 3);
    check("rst_ack", {31'd0, sdram_ack}, 0);
    check("rst_rdy", {31'd0, data_rdy}, 0);
    check("rst_data_read", data_read, 0);

    // Init with a read held pending the whole time: no ack until IDLE
    sdram_req = 1'b1; sdram_addr = 22'h000400; sb.push_back(32'hABCD1234);
    rstn = 1'b1; c0 = cyc;
    check_init(c0);

    // Read 0x00400: ACT row 2 col 0, reads at T+2/T+3, data_rdy at T+7
    wait_cmd(CMD_ACT, 20, "read_act_wait", t, a);
    check("read_act_cycle", t - c0, 4818);
    check("read_act_row", {19'd0, a}, 2);
    check("read_act_ba", {30'd0, sd_ba}, 0);
    check("read_ack", {31'd0, sdram_ack}, 1);
    sdram_req = 1'b0;
    wait_cmd(CMD_RD, 10, "read_rd1_wait", t2, a);
    check("read_rd1_cycle", t2 - t, 2);
    check("read_rd1_a", {19'd0, a}, 32'h000);
    wait_cmd(CMD_RD, 2, "read_rd2_wait", t2, a);
    check("read_rd2_cycle", t2 - t, 3);
    check("read_rd2_a", {19'd0, a}, 32'h401);
    wait_flag(1'b1, 20, "read_rdy_wait", t2);
    check("read_rdy_cycle", t2 - t, 7);

    // Refresh due with refresh_en and a simultaneous read: REF first
    repeat (400) @(negedge clk);
    refresh_en = 1'b1; sdram_req = 1'b1; sdram_addr = 22'h000400; sb.push_back(32'hABCD1234);
    c1 = cyc;
    wait_cmd(CMD_REF, 5, "due_ref_wait", t, a);
    check("due_ref_cycle", t - c1, 1);
    wait_cmd(CMD_ACT, 20, "due_act_wait", t2, a);
    check("due_act_after_ref", t2 - t, 8);
    check("due_act_ack", {31'd0, sdram_ack}, 1);
    sdram_req = 1'b0; refresh_en = 1'b0;
    wait_flag(1'b1, 20, "due_rdy_wait", t2);

    // Download byte write, low byte only
    downloading = 1'b1; prog_we = 1'b1; prog_addr = 22'h000011;
    prog_data = 8'h5A; prog_mask = 2'b10;
    wait_cmd(CMD_ACT, 20, "wr_act_wait", t, a);
    check("wr_ack", {31'd0, sdram_ack}, 1);
    check("wr_act_row", {19'd0, a}, 0);
    prog_we = 1'b0;
    wait_cmd(CMD_WR, 10, "wr_cmd_wait", t2, a);
    check("wr_cmd_cycle", t2 - t, 2);
    check("wr_cmd_a", {19'd0, a}, 32'h411);
    check("wr_dq_out", {16'd0, dq_out}, 32'h5A5A);
    check("wr_dqm", {30'd0, sd_dqm}, 2);
    check("wr_dq_oe", {31'd0, dq_oe}, 1);
    @(negedge clk);
    check("wr_dq_oe_after", {31'd0, dq_oe}, 0);
    check("wr_dqm_after", {30'd0, sd_dqm}, 3);
    repeat (4) @(negedge clk);
    check("wr_mem", {16'd0, mem[32'h011]}, 32'hC35A);

    // Priority while downloading: write wins, read never acked
    prog_we = 1'b1; prog_addr = 22'h000020; prog_data = 8'h77; prog_mask = 2'b00;
    sdram_req = 1'b1; sdram_addr = 22'h000020;
    wait_cmd(CMD_ACT, 20, "prio_act_wait", t, a);
    prog_we = 1'b0;
    repeat (2) @(negedge clk);
    check("prio_write_first", {28'd0, sd_cmd}, {28'd0, CMD_WR});
    acks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sdram_ack) acks++;
    end
    check("prio_no_read_ack", acks, 0);
    sb.push_back(32'h98767777);
    downloading = 1'b0;
    wait_flag(1'b0, 50, "prio_read_ack_wait", t);
    sdram_req = 1'b0;
    wait_flag(1'b1, 20, "prio_read_rdy_wait", t2);
    check("prio_read_latency", t2 - t, 7);

    // Reset in the middle of a read: no data_rdy, init repeats
    sdram_req = 1'b1; sdram_addr = 22'h000400;
    wait_cmd(CMD_ACT, 50, "rstmid_act_wait", t, a);
    sdram_req = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstmid_cmd", {28'd0, sd_cmd}, 32'h7);
    check("rstmid_data_read", data_read, 0);
    check("rstmid_dqm", {30'd0, sd_dqm}, 3);
    repeat (10) @(negedge clk);
    rstn = 1'b1; c0 = cyc;
    sdram_req = 1'b1; sdram_addr = 22'h000400;
    check_init(c0);

    // Back-to-back reads with refresh_en=0: overdue refresh still happens
    idle0 = c0 + 4817;
    nrd = 0;
    while (last_ref_cyc < idle0 && nrd < 120) begin
      sdram_req = 1'b1; sb.push_back(32'hABCD1234);
      wait_flag(1'b0, 50, "od_ack_wait", t);
      sdram_req = 1'b0;
      wait_flag(1'b1, 20, "od_rdy_wait", t2);
      nrd++;
    end
    n_checks++;
    if (last_ref_cyc - idle0 < 748 || last_ref_cyc - idle0 > 760) begin
      n_fail++;
      $display("FAIL overdue_ref_offset: got %0d cycles after IDLE, required 748..760",
               last_ref_cyc - idle0);
    end

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
